// File: rtl/button_pkg.sv
// Shared constants for the button front end: classifier state encoding and
// default timing, also used by the debouncer timer.
package button_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PRESSED     = 3'd1,
    ST_LONG_HELD   = 3'd2,
    ST_WAIT_GAP    = 3'd3,
    ST_SECOND_HELD = 3'd4
  } state_t;

  localparam int DEF_LONG_CYCLES   = 8;
  localparam int DEF_GAP_CYCLES    = 6;
  localparam int DEF_REPEAT_CYCLES = 4;
  localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/button_press_classifier_if.sv
// Button level in, classified one-cycle event pulses out.
interface button_press_classifier_if;

  logic debounced;
  logic short_press;
  logic long_press;
  logic double_press;
  logic repeat_press;
  logic busy;

  modport master (
    output debounced,
    input  short_press, long_press, double_press, repeat_press, busy
  );

  modport slave (
    input  debounced,
    output short_press, long_press, double_press, repeat_press, busy
  );

endinterface

// File: rtl/level_edge_detect.sv
// Registers the previous level sample and decodes rising/falling edges.
module level_edge_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= RESET_VAL;
    else       prev <= level;
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/button_press_classifier.sv
// Turns a debounced button level into short/long/double/repeat event pulses.
//   state       | meaning
//   IDLE        | waiting for a fresh rising edge
//   PRESSED     | first press held, timing towards long press
//   LONG_HELD   | long press fired, auto-repeat while held
//   WAIT_GAP    | released, waiting to see if a second press follows
//   SECOND_HELD | double fired, waiting for release
module button_press_classifier
  import button_pkg::*;
#(
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  button_press_classifier_if.slave  bus
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rise, fall_unused;
  logic             short_q, long_q, double_q, repeat_q;
  logic             short_nxt, long_nxt, double_nxt, repeat_nxt;

  // prev resets high so a button held through reset is not seen as a press
  level_edge_detect #(.RESET_VAL(1'b1)) u_edge (
    .clk   (clk),
    .reset (reset),
    .level (bus.debounced),
    .rise  (rise),
    .fall  (fall_unused)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      short_q  <= short_nxt;
      long_q   <= long_nxt;
      double_q <= double_nxt;
      repeat_q <= repeat_nxt;
    end
  end

  // Counter only advances in timed states and clears on every state change
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (rise) state_nxt = ST_PRESSED;
      end
      ST_PRESSED: begin
        if (!bus.debounced) begin
          state_nxt = ST_WAIT_GAP;
          cnt_nxt   = '0;
        end else if (cnt == LONG_LAST) begin
          state_nxt = ST_LONG_HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_LONG_HELD: begin
        if (!bus.debounced) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == REPEAT_LAST) begin
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_WAIT_GAP: begin
        if (bus.debounced) begin
          state_nxt = ST_SECOND_HELD;
          cnt_nxt   = '0;
        end else if (cnt == GAP_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_SECOND_HELD: begin
        cnt_nxt = '0;
        if (!bus.debounced) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    double_nxt = 1'b0;
    repeat_nxt = 1'b0;
    case (state)
      ST_PRESSED:   long_nxt   = bus.debounced && (cnt == LONG_LAST);
      ST_LONG_HELD: repeat_nxt = bus.debounced && (cnt == REPEAT_LAST);
      ST_WAIT_GAP: begin
        double_nxt = bus.debounced;
        short_nxt  = !bus.debounced && (cnt == GAP_LAST);
      end
      default: ;
    endcase
  end

  assign bus.short_press  = short_q;
  assign bus.long_press   = long_q;
  assign bus.double_press = double_q;
  assign bus.repeat_press = repeat_q;
  assign bus.busy         = (state != ST_IDLE);

endmodule
